// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command/response controller.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package uart_cmd_pkg;

    // Sensor command codes accepted in byte0 of a frame
    localparam logic [7:0] CMD_STATUS    = 8'h00;
    localparam logic [7:0] CMD_TEMP      = 8'h01;
    localparam logic [7:0] CMD_HUM       = 8'h02;
    localparam logic [7:0] CMD_TEMP_CONT = 8'h03;
    localparam logic [7:0] CMD_HUM_CONT  = 8'h04;

    // Response codes generated locally instead of by the sensor side
    localparam logic [7:0] ERR_CMD     = 8'hFE;
    localparam logic [7:0] ERR_ADDR    = 8'hFD;
    localparam logic [7:0] ERR_TIMEOUT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_B1,
        ST_CHECK,
        ST_REQ,
        ST_SEND_CODE,
        ST_WAIT_CODE,
        ST_SEND_DATA,
        ST_WAIT_DATA
    } state_e;

    // True when byte0 names one of the supported commands
    function automatic logic cmd_known(input logic [7:0] cmd);
        return cmd inside {CMD_STATUS, CMD_TEMP, CMD_HUM, CMD_TEMP_CONT, CMD_HUM_CONT};
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Saturating cycle counter with clear/enable and a terminal-count flag.
// Latency: clear/enable take effect on the next edge; tc_o is a decode of the count register.
// Backpressure: none; holds at TIMEOUT_CLKS until cleared.
module timeout_counter #(
    parameter int TIMEOUT_CLKS = 50000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int            CW   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CLKS);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear wins over enable; the count sticks at the terminal value instead of wrapping
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != TERM)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TERM);

endmodule

// File: rtl/uart_cmd_controller.sv
// Assembles (cmd, addr) frames from the UART RX, issues one sensor request, returns (code, data) via UART TX.
// Latency: error response TX pulse 2 cycles after byte1; request 2 cycles after byte1; code TX 2 cycles after ack.
// Backpressure: TX pulses wait for i_Tx_Active low; RX bytes arriving while busy are dropped.
module uart_cmd_controller
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 50000000,
    parameter int ADDR_MAX     = 31
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    input  logic       i_Tx_Active,
    input  logic       i_Tx_Done,
    output logic       o_Req,
    output logic [7:0] o_Req_Cmd,
    output logic [4:0] o_Req_Addr,
    input  logic       i_Ack,
    input  logic [7:0] i_Resp_Code,
    input  logic [7:0] i_Resp_Data,
    output logic       o_Busy
);

    localparam logic [7:0] ADDR_LIM = 8'(ADDR_MAX);

    state_e     state_q,    state_d;
    logic [7:0] cmd_q,      cmd_d;
    logic [7:0] addr_q,     addr_d;
    logic [7:0] code_q,     code_d;
    logic [7:0] data_q,     data_d;
    logic       tx_dv_q,    tx_dv_d;
    logic [7:0] tx_byte_q,  tx_byte_d;
    logic [7:0] req_cmd_q,  req_cmd_d;
    logic [4:0] req_addr_q, req_addr_d;

    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_tc;
    logic       cmd_bad;
    logic       addr_bad;
    logic [7:0] err_code;

    // One counter serves both the inter-byte window and the sensor ack window
    timeout_counter #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .clk_i  (i_Clock),
        .rst_ni (i_Reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    // Frame validation; the address is range-checked over the full received byte
    assign cmd_bad  = !cmd_known(cmd_q);
    assign addr_bad = (addr_q > ADDR_LIM);
    assign err_code = cmd_bad ? ERR_CMD : ERR_ADDR;

    // Next-state and datapath decode
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        code_d     = code_q;
        data_d     = data_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        req_cmd_d  = req_cmd_q;
        req_addr_d = req_addr_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Rx_DV) begin
                    cmd_d   = i_Rx_Byte;
                    cnt_clr = 1'b1;
                    state_d = ST_WAIT_B1;
                end
            end
            ST_WAIT_B1: begin
                cnt_en = 1'b1;
                if (i_Rx_DV) begin
                    addr_d  = i_Rx_Byte;
                    state_d = ST_CHECK;
                end else if (cnt_tc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                cnt_clr = 1'b1;
                if (cmd_bad || addr_bad) begin
                    code_d = err_code;
                    data_d = 8'h00;
                    // Launch the code byte straight away when the TX is free so the
                    // error reply starts two cycles after byte1
                    if (!i_Tx_Active) begin
                        tx_dv_d   = 1'b1;
                        tx_byte_d = err_code;
                        state_d   = ST_WAIT_CODE;
                    end else begin
                        state_d   = ST_SEND_CODE;
                    end
                end else begin
                    req_cmd_d  = cmd_q;
                    req_addr_d = addr_q[4:0];
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_en = 1'b1;
                if (i_Ack) begin
                    code_d  = i_Resp_Code;
                    data_d  = i_Resp_Data;
                    state_d = ST_SEND_CODE;
                end else if (cnt_tc) begin
                    code_d  = ERR_TIMEOUT;
                    data_d  = 8'h00;
                    state_d = ST_SEND_CODE;
                end
            end
            ST_SEND_CODE: begin
                if (!i_Tx_Active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = code_q;
                    state_d   = ST_WAIT_CODE;
                end
            end
            ST_WAIT_CODE: begin
                if (i_Tx_Done) begin
                    state_d = ST_SEND_DATA;
                end
            end
            ST_SEND_DATA: begin
                if (!i_Tx_Active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = data_q;
                    state_d   = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (i_Tx_Done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= 8'h00;
            addr_q     <= 8'h00;
            code_q     <= 8'h00;
            data_q     <= 8'h00;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            req_cmd_q  <= 8'h00;
            req_addr_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            code_q     <= code_d;
            data_q     <= data_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            req_cmd_q  <= req_cmd_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Req      = (state_q == ST_REQ);
    assign o_Req_Cmd  = req_cmd_q;
    assign o_Req_Addr = req_addr_q;
    assign o_Busy     = (state_q != ST_IDLE) && (state_q != ST_WAIT_B1);

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Scoreboard bench: stimulus pushes expected TX bytes and requests, monitors pop and compare.
// Reference model derives responses directly from the frame rules and the sensor behaviour chosen by the stimulus.
module tb_uart_cmd_controller;

    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       i_Reset;
    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Byte;
    logic       i_Tx_Active;
    logic       i_Tx_Done;
    logic       o_Req;
    logic [7:0] o_Req_Cmd;
    logic [4:0] o_Req_Addr;
    logic       i_Ack;
    logic [7:0] i_Resp_Code;
    logic [7:0] i_Resp_Data;
    logic       o_Busy;

    logic       tx_model_active;
    logic       force_active;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]  exp_tx[$];
    logic [12:0] exp_req[$];
    int          dv_cycs[$];
    int          req_rise_cyc = 0;
    int          req_fall_cyc = 0;
    logic        prev_dv = 1'b0;
    logic        prev_req = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign i_Tx_Active = tx_model_active | force_active;

    uart_cmd_controller #(
        .TIMEOUT_CLKS (TO),
        .ADDR_MAX     (31)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (i_Reset),
        .i_Rx_DV     (i_Rx_DV),
        .i_Rx_Byte   (i_Rx_Byte),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done),
        .o_Req       (o_Req),
        .o_Req_Cmd   (o_Req_Cmd),
        .o_Req_Addr  (o_Req_Addr),
        .i_Ack       (i_Ack),
        .i_Resp_Code (i_Resp_Code),
        .i_Resp_Data (i_Resp_Data),
        .o_Busy      (o_Busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rule: 0 means a valid frame, otherwise the error code to return
    function automatic logic [7:0] model_err(input logic [7:0] c, input logic [7:0] a);
        if (c > 8'h04) return 8'hFE;
        if (a > 8'd31) return 8'hFD;
        return 8'h00;
    endfunction

    // TX monitor: every pulse must be isolated, not under an active TX, and match the scoreboard
    always @(negedge clk) begin
        if (o_Tx_DV) begin
            check("tx_dv_back_to_back", {31'd0, prev_dv}, 32'd0);
            check("tx_dv_while_active", {31'd0, i_Tx_Active}, 32'd0);
            dv_cycs.push_back(cyc);
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got byte 0x%02h, expected no transmission", o_Tx_Byte);
            end else begin
                check("tx_byte", {24'd0, o_Tx_Byte}, {24'd0, exp_tx.pop_front()});
            end
        end
        prev_dv = o_Tx_DV;
    end

    // Request monitor: each rising o_Req must match the next expected (cmd, addr)
    always @(negedge clk) begin
        if (o_Req && !prev_req) begin
            req_rise_cyc = cyc;
            if (exp_req.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected: got cmd 0x%02h addr %0d, expected no request", o_Req_Cmd, o_Req_Addr);
            end else begin
                logic [12:0] e;
                e = exp_req.pop_front();
                check("req_cmd", {24'd0, o_Req_Cmd}, {24'd0, e[12:5]});
                check("req_addr", {27'd0, o_Req_Addr}, {27'd0, e[4:0]});
            end
        end
        if (!o_Req && prev_req) req_fall_cyc = cyc;
        prev_req = o_Req;
    end

    // Transmitter model: busy for a random number of cycles per byte, byte must stay stable
    initial begin
        logic [7:0] b;
        tx_model_active = 1'b0;
        i_Tx_Done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_Tx_DV) begin
                b = o_Tx_Byte;
                @(posedge clk);
                #1 tx_model_active = 1'b1;
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1 tx_model_active = 1'b0;
                i_Tx_Done = 1'b1;
                check("tx_byte_stable", {24'd0, o_Tx_Byte}, {24'd0, b});
                @(posedge clk);
                #1 i_Tx_Done = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, output int n);
        @(posedge clk);
        #1 i_Rx_DV = 1'b1;
        i_Rx_Byte = b;
        n = cyc;
        @(posedge clk);
        #1 i_Rx_DV = 1'b0;
        i_Rx_Byte = 8'($urandom);
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!o_Busy && exp_tx.size() == 0 && !tx_model_active && !i_Tx_Done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, limit);
        end
    endtask

    // mode 0: ack after dly cycles; 1: never ack; 2: ack on the terminal-count cycle
    task automatic run_frame(input logic [7:0] c, input logic [7:0] a, input int mode, input int dly,
                             input logic [7:0] rc, input logic [7:0] rd, input int gap);
        int n, m, b0;
        logic [7:0] e;
        dv_cycs.delete();
        send_byte(c, b0);
        repeat (gap) @(posedge clk);
        send_byte(a, n);
        e = model_err(c, a);
        if (e != 8'h00) begin
            exp_tx.push_back(e);
            exp_tx.push_back(8'h00);
            @(negedge clk);
            @(negedge clk);
            check("req_low_on_error", {31'd0, o_Req}, 32'd0);
            wait_idle("idle_after_error", 200);
            if (dv_cycs.size() > 0) check("err_code_latency", dv_cycs[0], n + 2);
        end else begin
            exp_req.push_back({c, a[4:0]});
            @(negedge clk);
            @(negedge clk);
            check("req_rise_latency", {31'd0, o_Req}, 32'd1);
            if (mode == 1) begin
                exp_tx.push_back(8'hFF);
                exp_tx.push_back(8'h00);
                wait_idle("idle_after_timeout", TO + 300);
                check("req_high_cycles", req_fall_cyc - req_rise_cyc, TO + 1);
                if (dv_cycs.size() > 0) check("timeout_code_latency", dv_cycs[0], n + TO + 4);
            end else begin
                if (mode == 2) repeat (TO) @(posedge clk);
                else repeat (dly) @(posedge clk);
                #1 i_Ack = 1'b1;
                i_Resp_Code = rc;
                i_Resp_Data = rd;
                m = cyc;
                exp_tx.push_back(rc);
                exp_tx.push_back(rd);
                @(posedge clk);
                #1 i_Ack = 1'b0;
                i_Resp_Code = 8'($urandom);
                i_Resp_Data = 8'($urandom);
                @(negedge clk);
                check("req_drop_after_ack", {31'd0, o_Req}, 32'd0);
                wait_idle("idle_after_ack", 200);
                if (dv_cycs.size() > 0) check("ack_code_latency", dv_cycs[0], m + 2);
            end
        end
        check("response_pair_count", dv_cycs.size(), 2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_dv"},    {31'd0, o_Tx_DV},    32'd0);
        check({tag, "_tx_byte"},  {24'd0, o_Tx_Byte},  32'd0);
        check({tag, "_req"},      {31'd0, o_Req},      32'd0);
        check({tag, "_req_cmd"},  {24'd0, o_Req_Cmd},  32'd0);
        check({tag, "_req_addr"}, {27'd0, o_Req_Addr}, 32'd0);
        check({tag, "_busy"},     {31'd0, o_Busy},     32'd0);
    endtask

    initial begin
        int n, r, b0;
        i_Reset = 1'b0;
        i_Rx_DV = 1'b0;
        i_Rx_Byte = 8'h00;
        i_Ack = 1'b0;
        i_Resp_Code = 8'h00;
        i_Resp_Data = 8'h00;
        force_active = 1'b0;

        repeat (3) @(posedge clk);
        #1 i_Reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Valid request with a 20-cycle sensor latency
        run_frame(8'h01, 8'h05, 0, 20, 8'h09, 8'h1A, 0);

        // Bad command, bad address, both bad (command wins)
        run_frame(8'h07, 8'h02, 0, 0, 8'h00, 8'h00, 0);
        run_frame(8'h01, 8'h20, 0, 0, 8'h00, 8'h00, 0);
        run_frame(8'h05, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
        run_frame(8'h04, 8'd31, 0, 3, 8'h77, 8'h88, 0);

        // Sensor timeout, then ack on the terminal cycle
        run_frame(8'h02, 8'h03, 1, 0, 8'h00, 8'h00, 0);
        run_frame(8'h02, 8'h03, 2, 0, 8'h33, 8'h44, 0);

        // Lone byte0 expires silently; next frame answered once
        dv_cycs.delete();
        send_byte(8'h01, b0);
        repeat (1100) @(posedge clk);
        @(negedge clk);
        check("busy_after_interbyte_timeout", {31'd0, o_Busy}, 32'd0);
        check("no_tx_after_interbyte_timeout", dv_cycs.size(), 0);
        run_frame(8'h00, 8'h01, 0, 5, 8'h12, 8'h34, 0);

        // byte1 on the last cycle before the inter-byte timeout is still accepted
        run_frame(8'h03, 8'h0A, 0, 2, 8'h56, 8'h78, 998);

        // Backpressure on the code byte with an RX byte injected during SEND_CODE
        dv_cycs.delete();
        send_byte(8'h04, b0);
        send_byte(8'h10, n);
        exp_req.push_back({8'h04, 5'h10});
        repeat (5) @(posedge clk);
        #1 force_active = 1'b1;
        i_Ack = 1'b1;
        i_Resp_Code = 8'h5A;
        i_Resp_Data = 8'hA5;
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'hA5);
        @(posedge clk);
        #1 i_Ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_Rx_DV = 1'b1;
        i_Rx_Byte = 8'hAA;
        @(posedge clk);
        #1 i_Rx_DV = 1'b0;
        repeat (45) @(posedge clk);
        @(negedge clk);
        check("busy_under_backpressure", {31'd0, o_Busy}, 32'd1);
        check("no_tx_under_backpressure", dv_cycs.size(), 0);
        @(posedge clk);
        #1 force_active = 1'b0;
        r = cyc;
        wait_idle("idle_after_backpressure", 200);
        if (dv_cycs.size() > 0) check("tx_after_release_latency", dv_cycs[0], r + 1);
        check("backpressure_pair_count", dv_cycs.size(), 2);
        run_frame(8'h00, 8'h1F, 0, 4, 8'hC3, 8'h3C, 0);

        // Reset asserted while waiting for the sensor
        dv_cycs.delete();
        send_byte(8'h03, b0);
        send_byte(8'h07, n);
        exp_req.push_back({8'h03, 5'h07});
        repeat (10) @(posedge clk);
        #1 i_Reset = 1'b0;
        @(posedge clk);
        #1 i_Reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (TO + 20) @(posedge clk);
        @(negedge clk);
        check("no_tx_after_midreset", dv_cycs.size(), 0);
        run_frame(8'h00, 8'h02, 0, 6, 8'h61, 8'h62, 0);

        // Randomized frames against the reference rules
        for (int t = 0; t < 40; t++) begin
            logic [7:0] c, a;
            int mode;
            c = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(5, 255));
            a = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(32, 255));
            mode = ($urandom_range(0, 11) == 0) ? 1 : 0;
            run_frame(c, a, mode, $urandom_range(1, 40), 8'($urandom), 8'($urandom), 0);
        end

        repeat (5) @(posedge clk);
        check("tx_scoreboard_drained", exp_tx.size(), 0);
        check("req_scoreboard_drained", exp_req.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
